fft_frame_capture: RTL and testbench

FFT_FRAME_CAPTURE -- requirements
Module: fft_frame_capture

---
 rtl/fft_frame_capture.sv | 199 +++++++++++++++++++
 tb/tb_fft_frame_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_capture
//  Brief    : Captures one FFT frame into a buffer, then streams it out with
//             valid/ready handshake. Optional peak detector: FFT_CAP_PEAK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_capture #(
    parameter int WIDTH    = 16,
    parameter int N_POINTS = 32,
    parameter int GROUP    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        all_fft_done,
    input  logic signed [WIDTH-1:0]     data_real_out,
    input  logic signed [WIDTH-1:0]     data_imag_out,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [WIDTH-1:0]     m_real,
    output logic signed [WIDTH-1:0]     m_imag,
    output logic [$clog2(N_POINTS)-1:0] m_index,
    output logic                        group_last,
    output logic                        frame_last,
    output logic                        busy,
    output logic                        overrun
`ifdef FFT_CAP_PEAK_EN
    ,
    output logic [WIDTH:0]              peak_mag,
    output logic [$clog2(N_POINTS)-1:0] peak_index,
    output logic                        peak_valid
`endif
);

    localparam int c_AW = $clog2(N_POINTS);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(N_POINTS - 1);
    localparam logic [c_AW-1:0] c_GMASK = c_AW'(GROUP - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t r_state;
    logic [c_AW-1:0] r_wr_cnt;
    logic [c_AW-1:0] r_rd_cnt;
    logic r_done_q;
    logic r_armed;

    logic signed [WIDTH-1:0] r_buf_re [N_POINTS];
    logic signed [WIDTH-1:0] r_buf_im [N_POINTS];

    logic w_start;
    logic w_last_rd;
    logic w_xfer;
    logic w_restart;
    logic w_begin;
    logic w_load;
    logic w_wr_en;
    logic w_overrun_evt;
    logic [c_AW-1:0] w_ld_idx;
    logic [c_AW-1:0] w_wr_addr;

    // r_armed blocks a start until done has been seen low since reset
    assign w_start       = all_fft_done & ~r_done_q & r_armed;
    assign w_last_rd     = (r_rd_cnt == c_LAST);
    assign w_xfer        = (r_state == S_DRAIN) && m_valid && m_ready;
    assign w_restart     = w_xfer && w_last_rd && w_start;
    assign w_begin       = ((r_state == S_IDLE) && w_start) || w_restart;
    assign w_load        = (r_state == S_DRAIN) && (!m_valid || (m_ready && !w_last_rd));
    assign w_ld_idx      = m_valid ? (r_rd_cnt + c_AW'(1)) : r_rd_cnt;
    assign w_wr_en       = w_begin || (r_state == S_CAPTURE);
    assign w_wr_addr     = (r_state == S_CAPTURE) ? r_wr_cnt : '0;
    assign w_overrun_evt = w_start && ((r_state == S_CAPTURE) ||
                                       ((r_state == S_DRAIN) && !w_restart));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf_re[w_wr_addr] <= data_real_out;
            r_buf_im[w_wr_addr] <= data_imag_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_done_q   <= 1'b0;
            r_armed    <= 1'b0;
            m_valid    <= 1'b0;
            m_real     <= '0;
            m_imag     <= '0;
            m_index    <= '0;
            group_last <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_done_q <= all_fft_done;
            r_armed  <= r_armed | ~all_fft_done;
            if (w_overrun_evt) begin
                overrun <= 1'b1;
            end
            // First DRAIN cycle prefetches; afterwards each transfer loads the next bin
            if (w_load) begin
                m_valid    <= 1'b1;
                m_real     <= r_buf_re[w_ld_idx];
                m_imag     <= r_buf_im[w_ld_idx];
                m_index    <= w_ld_idx;
                group_last <= ((w_ld_idx & c_GMASK) == c_GMASK);
                frame_last <= (w_ld_idx == c_LAST);
                r_rd_cnt   <= w_ld_idx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_begin) begin
                        r_state  <= S_CAPTURE;
                        r_wr_cnt <= c_AW'(1);
                        busy     <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_wr_cnt <= r_wr_cnt + c_AW'(1);
                    if (r_wr_cnt == c_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && w_last_rd) begin
                        m_valid    <= 1'b0;
                        group_last <= 1'b0;
                        frame_last <= 1'b0;
                        r_rd_cnt   <= '0;
                        if (w_restart) begin
                            r_state  <= S_CAPTURE;
                            r_wr_cnt <= c_AW'(1);
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_CAP_PEAK_EN
    logic [WIDTH:0]   w_mag;
    logic [WIDTH:0]   r_pk_mag;
    logic [c_AW-1:0]  r_pk_idx;
    logic             w_new_max;

    // Widen before negating so the most negative input yields 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] neg;
        ext = {x[WIDTH-1], x};
        neg = -ext;
        return x[WIDTH-1] ? neg[WIDTH-1:0] : x;
    endfunction

    assign w_mag     = {1'b0, abs_val(data_real_out)} + {1'b0, abs_val(data_imag_out)};
    assign w_new_max = (w_mag > r_pk_mag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pk_mag   <= '0;
            r_pk_idx   <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (w_begin) begin
                r_pk_mag <= w_mag;
                r_pk_idx <= '0;
            end else if (r_state == S_CAPTURE) begin
                if (w_new_max) begin
                    r_pk_mag <= w_mag;
                    r_pk_idx <= r_wr_cnt;
                end
                if (r_wr_cnt == c_LAST) begin
                    peak_valid <= 1'b1;
                    peak_mag   <= w_new_max ? w_mag : r_pk_mag;
                    peak_index <= w_new_max ? r_wr_cnt : r_pk_idx;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_capture
//  Brief    : Directed scoreboard bench for fft_frame_capture.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_capture;

    localparam int WIDTH = 16;
    localparam int N     = 32;
    localparam int GROUP = 4;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             all_fft_done;
    logic [WIDTH-1:0] data_real_out;
    logic [WIDTH-1:0] data_imag_out;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_real;
    logic [WIDTH-1:0] m_imag;
    logic [AW-1:0]    m_index;
    logic             group_last;
    logic             frame_last;
    logic             busy;
    logic             overrun;
`ifdef FFT_CAP_PEAK_EN
    logic [WIDTH:0]   peak_mag;
    logic [AW-1:0]    peak_index;
    logic             peak_valid;
`endif

    fft_frame_capture #(.WIDTH(WIDTH), .N_POINTS(N), .GROUP(GROUP)) dut (
        .clk          (clk),
        .reset        (reset),
        .all_fft_done (all_fft_done),
        .data_real_out(data_real_out),
        .data_imag_out(data_imag_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_real       (m_real),
        .m_imag       (m_imag),
        .m_index      (m_index),
        .group_last   (group_last),
        .frame_last   (frame_last),
        .busy         (busy),
        .overrun      (overrun)
`ifdef FFT_CAP_PEAK_EN
        ,
        .peak_mag     (peak_mag),
        .peak_index   (peak_index),
        .peak_valid   (peak_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [AW-1:0]    idx;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_xfer = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat_re(input int kind, input int i);
        case (kind)
            0:       return WIDTH'(i);
            2:       return (i == 5) ? 16'h8000 : 16'h007f;
            default: return WIDTH'(i * 1031 + kind * 7919);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pat_im(input int kind, input int i);
        case (kind)
            0:       return WIDTH'(-i);
            2:       return '0;
            default: return WIDTH'(~(i * 977) ^ kind);
        endcase
    endfunction

    // Scoreboard monitor: pops one expected sample per handshake, checks stall hold
    logic             stall_q = 1'b0;
    logic [WIDTH-1:0] hold_re, hold_im;
    logic [AW-1:0]    hold_idx;
    logic             hold_gl, hold_fl;

    always @(negedge clk) begin
        if (!reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_real",  64'(m_real),  64'(hold_re));
                check("hold_imag",  64'(m_imag),  64'(hold_im));
                check("hold_index", 64'(m_index), 64'(hold_idx));
                check("hold_flags", 64'({group_last, frame_last}), 64'({hold_gl, hold_fl}));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'(1));
                end else begin
                    e_mon = sb.pop_front();
                    check("out_real",  64'(m_real),     64'(e_mon.re));
                    check("out_imag",  64'(m_imag),     64'(e_mon.im));
                    check("out_index", 64'(m_index),    64'(e_mon.idx));
                    check("group_last", 64'(group_last),
                          64'((int'(e_mon.idx) % GROUP) == GROUP - 1));
                    check("frame_last", 64'(frame_last), 64'(int'(e_mon.idx) == N - 1));
                    n_xfer++;
                end
            end
            stall_q  = m_valid && !m_ready;
            hold_re  = m_real;
            hold_im  = m_imag;
            hold_idx = m_index;
            hold_gl  = group_last;
            hold_fl  = frame_last;
        end
    end

    // Called #1 after a posedge; leaves all_fft_done low afterwards
    task automatic drive_frame(input int kind, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            all_fft_done  = 1'b1;
            data_real_out = pat_re(kind, i);
            data_imag_out = pat_im(kind, i);
            sb.push_back('{re: data_real_out, im: data_imag_out, idx: AW'(i)});
            @(posedge clk); #1;
        end
        all_fft_done = 1'b0;
    endtask

    // mode 0: always ready; 1: ready 1,0,0,1; 2: ready, done pulses low then high
    task automatic drain(input int mode, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || m_valid) && k < budget) begin
            m_ready = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (mode == 2) all_fft_done = !(k == 3 || k == 4);
            @(posedge clk); #1;
            k++;
        end
        m_ready = 1'b1;
        check("drain_left", 64'(sb.size()), 64'(0));
        check("drain_idle_valid", 64'(m_valid), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int k;
        reset = 1'b0; all_fft_done = 1'b0; m_ready = 1'b0;
        data_real_out = '0; data_imag_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   64'(m_valid), 64'(0));
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_data",    64'({m_real, m_imag, m_index}), 64'(0));
        check("rst_flags",   64'({group_last, frame_last}),  64'(0));
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;

        // Basic frame and first-valid latency
        x0 = n_xfer;
        drive_frame(0, N);
        @(negedge clk);
        check("basic_prefetch_valid", 64'(m_valid), 64'(0));
        check("basic_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("basic_first_valid", 64'(m_valid), 64'(1));
        @(posedge clk); #1;
        drain(0, 200);
        check("basic_count", 64'(n_xfer - x0), 64'(N));
        check("basic_busy_end", 64'(busy), 64'(0));

        // Backpressure
        x0 = n_xfer;
        drive_frame(1, N);
        drain(1, 400);
        check("bp_count", 64'(n_xfer - x0), 64'(N));

        // Back-to-back: new done edge on the final transfer edge
        x0 = n_xfer;
        drive_frame(3, N);
        k = 0;
        while (!(m_valid && m_index == AW'(N - 1)) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_reach_last", 64'(m_index), 64'(N - 1));
        drive_frame(4, N);
        drain(0, 200);
        check("b2b_count",   64'(n_xfer - x0), 64'(2 * N));
        check("b2b_overrun", 64'(overrun), 64'(0));

        // Overrun: done toggles during DRAIN
        x0 = n_xfer;
        drive_frame(5, N);
        check("ovr_before", 64'(overrun), 64'(0));
        drain(2, 200);
        check("ovr_set",   64'(overrun), 64'(1));
        check("ovr_count", 64'(n_xfer - x0), 64'(N));
        check("ovr_idle",  64'(busy), 64'(0));
        repeat (3) @(posedge clk); #1;
        check("ovr_sticky", 64'(overrun), 64'(1));

        // Reset during capture at sample 10
        drive_frame(6, 10);
        all_fft_done = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_valid",   64'(m_valid), 64'(0));
        check("mid_rst_busy",    64'(busy),    64'(0));
        check("mid_rst_overrun", 64'(overrun), 64'(0));
        check("mid_rst_data",    64'({m_real, m_imag, m_index, group_last, frame_last}), 64'(0));
        sb.delete();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("no_start_held_done", 64'(busy), 64'(0));
        all_fft_done = 1'b0;
        @(posedge clk); #1;
        x0 = n_xfer;
        drive_frame(7, N);
        drain(0, 200);
        check("clean_count", 64'(n_xfer - x0), 64'(N));

`ifdef FFT_CAP_PEAK_EN
        drive_frame(2, N);
        @(negedge clk);
        check("peak_valid", 64'(peak_valid), 64'(1));
        check("peak_index", 64'(peak_index), 64'(5));
        check("peak_mag",   64'(peak_mag),   64'(17'h08000));
        @(negedge clk);
        check("peak_pulse", 64'(peak_valid), 64'(0));
        check("peak_hold",  64'(peak_mag),   64'(17'h08000));
        @(posedge clk); #1;
        drain(0, 200);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
